// File: rtl/mem_bus_arbiter.sv
// Two-channel (fetch/data) arbiter feeding one downstream MMU port, one transaction outstanding.
// Define ARB_ROUND_ROBIN_EN to make contested grants alternate instead of data-first priority.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT      = 1024,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  output logic        dn_req_enable,
  output logic        dn_req_mode,
  output logic [31:0] dn_req_addr,
  output logic [31:0] dn_req_wdata,
  output logic [3:0]  dn_req_wstrb,
  input  logic        dn_resp_enable,
  input  logic [31:0] dn_resp_data,
  output logic        timeout_err
);

  // state | meaning
  // IDLE  | no downstream transaction; grant a pending slot if any
  // BUSY  | one transaction issued, waiting for dn_resp_enable or watchdog
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t state, state_nxt;

  logic        f_pend, m_pend;
  logic        f_mode, m_mode;
  logic [31:0] f_addr, m_addr, f_wdata, m_wdata;
  logic [3:0]  f_wstrb, m_wstrb;
  logic        owner_mem;
  logic [TW-1:0] to_cnt;

  logic sel_valid, sel_mem, done, to_fire, to_expired;
  logic f_take, m_take, pick_mem;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_mem;

  // Only contested grants move the flag, so an uncontested grant never steals a turn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_mem <= 1'b0;
    end else if (sel_valid && f_pend && m_pend) begin
      last_mem <= sel_mem;
    end
  end

  assign pick_mem = m_pend && (!f_pend || !last_mem);
`else
  assign pick_mem = m_pend;
`endif

  assign to_expired = (TIMEOUT != 0) && (to_cnt == '0);

  assign f_take = fetch_request_enable && !f_pend && !(state == BUSY && !owner_mem);
  assign m_take = mem_request_enable   && !m_pend && !(state == BUSY &&  owner_mem);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_valid = 1'b0;
    sel_mem   = 1'b0;
    done      = 1'b0;
    to_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (f_pend || m_pend) begin
          sel_valid = 1'b1;
          sel_mem   = pick_mem;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (dn_resp_enable) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (to_expired) begin
          done      = 1'b1;
          to_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_pend  <= 1'b0;
      f_mode  <= 1'b0;
      f_addr  <= '0;
      f_wdata <= '0;
      f_wstrb <= '0;
      m_pend  <= 1'b0;
      m_mode  <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else begin
      if (f_take) begin
        f_pend  <= 1'b1;
        f_mode  <= freq_mode;
        f_addr  <= freq_addr;
        f_wdata <= freq_wdata;
        f_wstrb <= freq_wstrb;
      end else if (sel_valid && !sel_mem) begin
        f_pend <= 1'b0;
      end
      if (m_take) begin
        m_pend  <= 1'b1;
        m_mode  <= mreq_mode;
        m_addr  <= mreq_addr;
        m_wdata <= mreq_wdata;
        m_wstrb <= mreq_wstrb;
      end else if (sel_valid && sel_mem) begin
        m_pend <= 1'b0;
      end
    end
  end

  // Downstream payload stays registered after the pulse until the next grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dn_req_enable <= 1'b0;
      dn_req_mode   <= 1'b0;
      dn_req_addr   <= '0;
      dn_req_wdata  <= '0;
      dn_req_wstrb  <= '0;
      owner_mem     <= 1'b0;
      to_cnt        <= '0;
    end else begin
      dn_req_enable <= sel_valid;
      if (sel_valid) begin
        owner_mem    <= sel_mem;
        dn_req_mode  <= sel_mem ? m_mode  : f_mode;
        dn_req_addr  <= sel_mem ? m_addr  : f_addr;
        dn_req_wdata <= sel_mem ? m_wdata : f_wdata;
        dn_req_wstrb <= sel_mem ? m_wstrb : f_wstrb;
        to_cnt       <= TO_LOAD;
      end else if (state == BUSY && to_cnt != '0) begin
        to_cnt <= to_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_response_enable <= 1'b0;
      mem_response_enable   <= 1'b0;
      fresp_data            <= '0;
      mresp_data            <= '0;
      timeout_err           <= 1'b0;
    end else begin
      fetch_response_enable <= done && !owner_mem;
      mem_response_enable   <= done &&  owner_mem;
      timeout_err           <= to_fire;
      if (done && !owner_mem) fresp_data <= to_fire ? TIMEOUT_DATA : dn_resp_data;
      if (done &&  owner_mem) mresp_data <= to_fire ? TIMEOUT_DATA : dn_resp_data;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected downstream requests and
// upstream responses into queues, a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fetch_request_enable = 1'b0, freq_mode = 1'b0;
  logic [31:0] freq_addr = '0, freq_wdata = '0;
  logic [3:0]  freq_wstrb = '0;
  logic        mem_request_enable = 1'b0, mreq_mode = 1'b0;
  logic [31:0] mreq_addr = '0, mreq_wdata = '0;
  logic [3:0]  mreq_wstrb = '0;
  logic        dn_resp_enable = 1'b0;
  logic [31:0] dn_resp_data = '0;
  logic        fetch_response_enable, mem_response_enable, timeout_err;
  logic [31:0] fresp_data, mresp_data;
  logic        dn_req_enable, dn_req_mode;
  logic [31:0] dn_req_addr, dn_req_wdata;
  logic [3:0]  dn_req_wstrb;

  mem_bus_arbiter #(.TIMEOUT(TO), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rstn(rstn),
    .fetch_request_enable(fetch_request_enable), .freq_mode(freq_mode), .freq_addr(freq_addr),
    .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
    .fetch_response_enable(fetch_response_enable), .fresp_data(fresp_data),
    .mem_request_enable(mem_request_enable), .mreq_mode(mreq_mode), .mreq_addr(mreq_addr),
    .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
    .mem_response_enable(mem_response_enable), .mresp_data(mresp_data),
    .dn_req_enable(dn_req_enable), .dn_req_mode(dn_req_mode), .dn_req_addr(dn_req_addr),
    .dn_req_wdata(dn_req_wdata), .dn_req_wstrb(dn_req_wstrb),
    .dn_resp_enable(dn_resp_enable), .dn_resp_data(dn_resp_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dn_exp_t;

  typedef struct {
    logic        mem;
    logic [31:0] data;
    logic        to;
  } rsp_exp_t;

  dn_exp_t  dn_q[$];
  rsp_exp_t rsp_q[$];
  dn_exp_t  e_dn;
  rsp_exp_t e_rsp;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic        prev_req = 1'b0, prev_resp = 1'b0;
  int          since = 0;
  logic [31:0] last_addr = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_req  = 1'b0;
      prev_resp = 1'b0;
    end else begin
      if (dn_req_enable) begin
        chk("dn_pulse_width", prev_req, 0);
        if (dn_q.size() == 0) chk("dn_unexpected", 1, 0);
        else begin
          e_dn = dn_q.pop_front();
          chk("dn_mode",  dn_req_mode,  e_dn.mode);
          chk("dn_addr",  dn_req_addr,  e_dn.addr);
          chk("dn_wdata", dn_req_wdata, e_dn.wdata);
          chk("dn_wstrb", dn_req_wstrb, e_dn.wstrb);
          last_addr = e_dn.addr;
        end
        since = 0;
      end else begin
        since++;
      end
      if (fetch_response_enable || mem_response_enable) begin
        chk("resp_both", fetch_response_enable && mem_response_enable, 0);
        if (rsp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e_rsp = rsp_q.pop_front();
          chk("resp_channel", mem_response_enable, e_rsp.mem);
          chk("resp_data", e_rsp.mem ? mresp_data : fresp_data, e_rsp.data);
          chk("timeout_err", timeout_err, e_rsp.to);
          if (e_rsp.to) chk("timeout_latency", since, TO);
          else          chk("resp_latency", prev_resp, 1);
          chk("dn_payload_hold", dn_req_addr, last_addr);
        end
      end else if (timeout_err) begin
        chk("timeout_stray", 1, 0);
      end
      prev_req  = dn_req_enable;
      prev_resp = dn_resp_enable;
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic mode, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    fetch_request_enable = 1'b1;
    freq_mode = mode; freq_addr = addr; freq_wdata = wdata; freq_wstrb = wstrb;
  endtask

  task automatic drive_m(input logic mode, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    mem_request_enable = 1'b1;
    mreq_mode = mode; mreq_addr = addr; mreq_wdata = wdata; mreq_wstrb = wstrb;
  endtask

  task automatic send();
    tick();
    fetch_request_enable = 1'b0;
    mem_request_enable   = 1'b0;
  endtask

  task automatic push_dn(input logic mode, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    dn_exp_t d;
    d.mode = mode; d.addr = addr; d.wdata = wdata; d.wstrb = wstrb;
    dn_q.push_back(d);
  endtask

  task automatic push_rsp(input logic mem, input logic [31:0] data, input logic to);
    rsp_exp_t r;
    r.mem = mem; r.data = data; r.to = to;
    rsp_q.push_back(r);
  endtask

  task automatic wait_dn(output int n);
    n = 0;
    while (!dn_req_enable && n < 50) begin
      tick();
      n++;
    end
    if (!dn_req_enable) chk("dn_wait_expired", 1, 0);
  endtask

  task automatic respond(input logic mem, input logic [31:0] data);
    push_rsp(mem, data, 1'b0);
    dn_resp_enable = 1'b1;
    dn_resp_data   = data;
    tick();
    dn_resp_enable = 1'b0;
  endtask

  task automatic serve(input int d, input logic mem, input logic [31:0] data, output int n);
    wait_dn(n);
    repeat (d) tick();
    respond(mem, data);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((dn_q.size() != 0 || rsp_q.size() != 0) && k < 100) begin
      tick();
      k++;
    end
    if (dn_q.size() != 0 || rsp_q.size() != 0) chk("idle_wait_expired", 1, 0);
    repeat (3) tick();
  endtask

  function automatic logic any_out();
    return |{dn_req_enable, dn_req_mode, dn_req_addr, dn_req_wdata, dn_req_wstrb,
             fetch_response_enable, fresp_data, mem_response_enable, mresp_data, timeout_err};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int  n;
    logic rr_mem_first;
    tick();
    tick();
    chk("reset_outputs", any_out(), 0);
    rstn = 1'b1;
    tick();

    // Fetch read, reply after 3 cycles
    drive_f(1'b0, 32'h1000, 32'h0, 4'h0);
    push_dn(1'b0, 32'h1000, 32'h0, 4'h0);
    send();
    serve(3, 1'b0, 32'hAABBCCDD, n);
    chk("issue_latency", n, 1);
    wait_idle();

    // Simultaneous requests, two rounds
    for (int round = 0; round < 2; round++) begin
`ifdef ARB_ROUND_ROBIN_EN
      rr_mem_first = (round == 0);
`else
      rr_mem_first = 1'b1;
`endif
      drive_f(1'b0, 32'h1100 + round, 32'h0, 4'h0);
      drive_m(1'b1, 32'h2100 + round, 32'h0BAD0000 + round, 4'h5);
      if (rr_mem_first) begin
        push_dn(1'b1, 32'h2100 + round, 32'h0BAD0000 + round, 4'h5);
        push_dn(1'b0, 32'h1100 + round, 32'h0, 4'h0);
      end else begin
        push_dn(1'b0, 32'h1100 + round, 32'h0, 4'h0);
        push_dn(1'b1, 32'h2100 + round, 32'h0BAD0000 + round, 4'h5);
      end
      send();
      serve(2, rr_mem_first,  32'h11110000 + round, n);
      serve(1, !rr_mem_first, 32'h22220000 + round, n);
      wait_idle();
    end

    // Mem write; second mem request while in flight dropped; pending fetch keeps first payload
    drive_m(1'b1, 32'h2000, 32'h12345678, 4'hF);
    push_dn(1'b1, 32'h2000, 32'h12345678, 4'hF);
    send();
    wait_dn(n);
    drive_m(1'b0, 32'h3000, 32'h0, 4'h0);
    send();
    drive_f(1'b1, 32'h7000, 32'hCAFEF00D, 4'h3);
    push_dn(1'b1, 32'h7000, 32'hCAFEF00D, 4'h3);
    send();
    drive_f(1'b0, 32'h7100, 32'h0, 4'h0);
    send();
    respond(1'b1, 32'h0000A11C);
    serve(1, 1'b0, 32'h00000055, n);
    wait_idle();
    repeat (10) tick();

    // Request in the same cycle as its channel's response pulse is accepted
    drive_f(1'b0, 32'h8000, 32'h0, 4'h0);
    push_dn(1'b0, 32'h8000, 32'h0, 4'h0);
    send();
    serve(0, 1'b0, 32'h00008888, n);
    chk("resp_pulse_cycle", fetch_response_enable, 1);
    drive_f(1'b0, 32'h8100, 32'h0, 4'h0);
    push_dn(1'b0, 32'h8100, 32'h0, 4'h0);
    send();
    serve(1, 1'b0, 32'h00008181, n);
    wait_idle();

    // Watchdog on fetch, then late dn_resp in IDLE ignored
    drive_f(1'b0, 32'h4000, 32'h0, 4'h0);
    push_dn(1'b0, 32'h4000, 32'h0, 4'h0);
    push_rsp(1'b0, 32'hDEADBEEF, 1'b1);
    send();
    wait_idle();
    dn_resp_enable = 1'b1;
    dn_resp_data   = 32'h0000BAD1;
    tick();
    dn_resp_enable = 1'b0;
    repeat (5) tick();

    // Watchdog on mem channel
    drive_m(1'b0, 32'h4100, 32'h0, 4'h0);
    push_dn(1'b0, 32'h4100, 32'h0, 4'h0);
    push_rsp(1'b1, 32'hDEADBEEF, 1'b1);
    send();
    wait_idle();

    // dn_resp on the last watchdog cycle wins
    drive_m(1'b0, 32'h4400, 32'h0, 4'h0);
    push_dn(1'b0, 32'h4400, 32'h0, 4'h0);
    send();
    wait_dn(n);
    repeat (TO - 1) tick();
    respond(1'b1, 32'h0000600D);
    wait_idle();
    repeat (TO + 2) tick();

    // Reset mid-transaction
    drive_f(1'b0, 32'h5000, 32'h0, 4'h0);
    push_dn(1'b0, 32'h5000, 32'h0, 4'h0);
    send();
    wait_dn(n);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    chk("reset_async_outputs", any_out(), 0);
    tick();
    chk("reset_held_outputs", any_out(), 0);
    rstn = 1'b1;
    dn_resp_enable = 1'b1;
    dn_resp_data   = 32'h0000BAD2;
    tick();
    dn_resp_enable = 1'b0;
    repeat (5) tick();
    drive_f(1'b0, 32'h6000, 32'h0, 4'h0);
    push_dn(1'b0, 32'h6000, 32'h0, 4'h0);
    send();
    serve(2, 1'b0, 32'h00006666, n);
    chk("post_reset_latency", n, 1);
    wait_idle();
    repeat (5) tick();

    chk("dn_queue_drained", dn_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024, SHALL set the downstream response watchdog in cycles; 0 SHALL disable the watchdog.
REQ-002 Parameter TIMEOUT_DATA, default 32'hDEADBEEF, SHALL set the data returned upstream on a timeout.
REQ-003 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port rstn, input, 1: reset, asynchronous assert, active-low.
REQ-005 Ports fetch_request_enable/freq_mode/freq_addr/freq_wdata/freq_wstrb, input, 1/1/32/32/4: fetch channel request pulse and payload (mode 0=read, 1=write).
REQ-006 Ports fetch_response_enable/fresp_data, output, 1/32: fetch channel response pulse and data.
REQ-007 Ports mem_request_enable/mreq_mode/mreq_addr/mreq_wdata/mreq_wstrb, input, 1/1/32/32/4: data channel request pulse and payload.
REQ-008 Ports mem_response_enable/mresp_data, output, 1/32: data channel response pulse and data.
REQ-009 Ports dn_req_enable/dn_req_mode/dn_req_addr/dn_req_wdata/dn_req_wstrb, output, 1/1/32/32/4: merged downstream request to the MMU.
REQ-010 Ports dn_resp_enable/dn_resp_data, input, 1/32: downstream response pulse and data.
REQ-011 Port timeout_err, output, 1: one-cycle pulse when the watchdog fires.

Function
REQ-012 Each channel SHALL capture its payload into a pending slot in the cycle its request_enable is high.
REQ-013 A request on a channel whose slot is pending or in flight SHALL be ignored; the slot SHALL keep the original payload.
REQ-014 A request arriving in the same cycle as that channel's upstream response pulse SHALL be accepted.
REQ-015 The FSM SHALL have two states: IDLE and BUSY.
REQ-016 In IDLE with at least one slot pending, the arbiter SHALL select one channel, register its payload on dn_req_*, and enter BUSY.
REQ-017 dn_req_enable SHALL be a one-cycle pulse in the cycle after selection; dn_req_* payload SHALL hold stable until the response.
REQ-018 A request captured at cycle t SHALL issue downstream no earlier than cycle t+2 (capture at t, select at t+1, pulse at t+2).
REQ-019 In BUSY, dn_resp_enable at cycle t SHALL produce the owning channel's response_enable pulse at t+1 with resp data equal to dn_resp_data; state SHALL return to IDLE at t+1.
REQ-020 The non-owning channel's response_enable SHALL remain 0.
REQ-021 dn_resp_enable in IDLE SHALL be ignored.
REQ-022 With TIMEOUT>0, a counter SHALL clear on entry to BUSY. If TIMEOUT cycles elapse without dn_resp_enable, the owning channel SHALL receive a response with TIMEOUT_DATA, timeout_err SHALL pulse in the same cycle, and state SHALL return to IDLE.
REQ-023 A dn_resp_enable arriving in the same cycle as the timeout SHALL take precedence; no timeout SHALL be signalled.
REQ-024 The arbiter SHALL have at most one downstream transaction outstanding.

Reset
REQ-025 While rstn=0, the arbiter SHALL enter IDLE, clear both slots and the watchdog, and drive every output to 0 (dn_req_*, *_response_enable, fresp_data, mresp_data, timeout_err).
REQ-026 Reset asserted mid-transaction SHALL discard the in-flight transaction; no upstream response SHALL be produced for it after reset.

Configuration
REQ-027 Without ARB_ROUND_ROBIN_EN, selection SHALL be fixed-priority: the data channel wins over the fetch channel whenever both are pending.
REQ-028 With ARB_ROUND_ROBIN_EN defined, when both are pending the channel not granted last SHALL win; the last-grant flag SHALL reset to "fetch", so the data channel wins first.

Verification
REQ-029 Fetch read addr 0x1000; downstream replies 0xAABBCCDD after 3 cycles -> one dn_req pulse (mode 0, addr 0x1000); fetch_response_enable with 0xAABBCCDD one cycle after dn_resp; mem_response_enable stays 0.
REQ-030 Fetch and mem requests in the same cycle, default build -> mem issued first, fetch second. With ARB_ROUND_ROBIN_EN, repeating the test twice -> mem, fetch, then fetch, mem.
REQ-031 Mem write addr 0x2000, wdata 0x12345678, wstrb 0xF; second mem request 0x3000 while the first is in flight -> only 0x2000 issued; second request dropped.
REQ-032 TIMEOUT=8, no dn_resp -> after 8 BUSY cycles, the owning channel receives 0xDEADBEEF and timeout_err pulses once. Then dn_resp_enable arrives late in IDLE -> ignored.
REQ-033 rstn pulled low while BUSY, then a late dn_resp_enable -> all outputs 0 during reset; no upstream response afterwards; the next fetch issues normally.
